// File: rtl/ef_pin_mux_pkg.sv
// ---------------------------------------------------------------------------
// ef_pin_mux_pkg
// Shared definitions for the guarded pin multiplexer:
//   pad_state_t : per-pad state (ACTIVE drives the selected function,
//                 PARK holds the pad tristated while a selection settles)
//   CNT_W       : width of the per-pad park counter
//   clog2       : ceiling log2 usable in constant expressions
//   sel_width   : select field width for a given function count (min 1)
// ---------------------------------------------------------------------------
package ef_pin_mux_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_PARK   = 1'b1
  } pad_state_t;

  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) result = b + 1;
    end
    return result;
  endfunction

  function automatic int sel_width(input int nfunc);
    return (clog2(nfunc) < 1) ? 1 : clog2(nfunc);
  endfunction

endpackage

// File: rtl/ef_pin_mux_slice.sv
// ---------------------------------------------------------------------------
// ef_pin_mux_slice
// One pad of the pin multiplexer: selection registers, park FSM with guard
// counter, input synchroniser and the output/input function muxes.
//   clk, rst        : clock, asynchronous active-high reset
//   io_in           : raw pad input
//   io_out, io_oeb  : pad output and active-low output enable
//   p_in            : per-function input (idle level when not selected)
//   p_out, p_oeb    : per-function output and output enable
//   wr_en, wr_sel   : write strobe for this pad and the requested selection
//   cur_sel         : selection currently driving the pad
//   busy            : pad is parked
//   err             : previous-cycle write to this pad was out of range
// ---------------------------------------------------------------------------
module ef_pin_mux_slice
  import ef_pin_mux_pkg::*;
#(
  parameter int               NFUNC       = 4,
  parameter int               SELW        = 2,
  parameter int               GUARD       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NFUNC-1:0] IDLE_VAL    = {NFUNC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_in,
  output logic             io_out,
  output logic             io_oeb,
  output logic [NFUNC-1:0] p_in,
  input  logic [NFUNC-1:0] p_out,
  input  logic [NFUNC-1:0] p_oeb,
  input  logic             wr_en,
  input  logic [SELW-1:0]  wr_sel,
  output logic [SELW-1:0]  cur_sel,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD);
  // One extra bit so NFUNC itself is representable when NFUNC == 2**SELW.
  localparam logic [SELW:0]    NFUNC_V = (SELW + 1)'(NFUNC);

  pad_state_t       state_reg;
  logic [SELW-1:0]  cur_reg;
  logic [SELW-1:0]  pend_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             sel_valid;
  logic             sel_accept;
  logic             s_in;

  assign sel_valid  = ({1'b0, wr_sel} < NFUNC_V);
  assign sel_accept = wr_en && sel_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ACTIVE;
      cur_reg   <= '0;
      pend_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      // Out-of-range writes are dropped entirely; only the flag records them.
      err_reg <= wr_en && !sel_valid;
      case (state_reg)
        ST_ACTIVE: begin
          if (sel_accept && (wr_sel != cur_reg)) begin
            pend_reg  <= wr_sel;
            cnt_reg   <= GUARD_V;
            state_reg <= ST_PARK;
          end
        end
        ST_PARK: begin
          // A write while parked always restarts the guard, even if it
          // names the function that was active before the park.
          if (sel_accept) begin
            pend_reg <= wr_sel;
            cnt_reg  <= GUARD_V;
          end else if (cnt_reg == CNT_W'(1)) begin
            cur_reg   <= pend_reg;
            cnt_reg   <= '0;
            state_reg <= ST_ACTIVE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= ST_ACTIVE;
      endcase
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_in = io_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= io_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_reg[k] <= sync_reg[k-1];
          end
        end
      end
      assign s_in = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Loop over legal functions only so a select value never indexes past
  // the function vectors.
  always_comb begin
    io_out = 1'b0;
    io_oeb = 1'b1;
    p_in   = IDLE_VAL;
    for (int f = 0; f < NFUNC; f++) begin
      if ((state_reg == ST_ACTIVE) && (cur_reg == SELW'(f))) begin
        io_out  = p_out[f];
        io_oeb  = p_oeb[f];
        p_in[f] = s_in;
      end
    end
  end

  assign cur_sel = cur_reg;
  assign busy    = (state_reg == ST_PARK);
  assign err     = err_reg;

endmodule

// File: rtl/ef_pin_mux_guarded.sv
// ---------------------------------------------------------------------------
// ef_pin_mux_guarded
// Pin multiplexing fabric: routes each of COUNT pads to one of NFUNC
// peripheral functions. A selection change parks the pad (tristated, out=0)
// for GUARD cycles before the new function drives it.
//   clk, rst             : clock, asynchronous active-high reset
//   io_in/io_out/io_oeb  : pad ring side (oeb active-low)
//   p_in/p_out/p_oeb     : peripheral side, index i*NFUNC+f
//   sel_we/wmask/wdata   : masked selection write, field i at [i*SELW +: SELW]
//   cur_sel              : active selection per pad
//   sel_busy             : any pad parked
//   sel_err              : one-cycle pulse after an out-of-range write
// ---------------------------------------------------------------------------
module ef_pin_mux_guarded
  import ef_pin_mux_pkg::*;
#(
  parameter int               COUNT       = 16,
  parameter int               NFUNC       = 4,
  parameter int               GUARD       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NFUNC-1:0] IDLE_VAL    = {NFUNC{1'b1}},
  localparam int              SELW        = sel_width(NFUNC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COUNT-1:0]       io_in,
  output logic [COUNT-1:0]       io_out,
  output logic [COUNT-1:0]       io_oeb,
  output logic [COUNT*NFUNC-1:0] p_in,
  input  logic [COUNT*NFUNC-1:0] p_out,
  input  logic [COUNT*NFUNC-1:0] p_oeb,
  input  logic                   sel_we,
  input  logic [COUNT-1:0]       sel_wmask,
  input  logic [COUNT*SELW-1:0]  sel_wdata,
  output logic [COUNT*SELW-1:0]  cur_sel,
  output logic                   sel_busy,
  output logic                   sel_err
);

  logic [COUNT-1:0] busy_vec;
  logic [COUNT-1:0] err_vec;

  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_pad
      ef_pin_mux_slice #(
        .NFUNC       (NFUNC),
        .SELW        (SELW),
        .GUARD       (GUARD),
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_VAL    (IDLE_VAL)
      ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .io_in   (io_in[gi]),
        .io_out  (io_out[gi]),
        .io_oeb  (io_oeb[gi]),
        .p_in    (p_in[gi*NFUNC +: NFUNC]),
        .p_out   (p_out[gi*NFUNC +: NFUNC]),
        .p_oeb   (p_oeb[gi*NFUNC +: NFUNC]),
        .wr_en   (sel_we && sel_wmask[gi]),
        .wr_sel  (sel_wdata[gi*SELW +: SELW]),
        .cur_sel (cur_sel[gi*SELW +: SELW]),
        .busy    (busy_vec[gi]),
        .err     (err_vec[gi])
      );
    end
  endgenerate

  assign sel_busy = |busy_vec;
  assign sel_err  = |err_vec;

endmodule

// File: doc/ef_pin_mux_guarded.md
Name: ef_pin_mux_guarded

Overview:
Parametrised pin-multiplexing fabric: each of COUNT pads is routed to one of NFUNC peripheral functions. Selection is held in internal registers written through a masked write port. Every selection change parks the pad (tristated, out=0) for GUARD cycles before the new function takes over, so two peripherals never drive the pad back-to-back. The pad input is synchronised and delivered only to the selected function; unselected functions see an idle level. Sits between the pad ring and the peripheral subsystem; configured by a register-bank wrapper.

Parameters:
COUNT, 16, number of pads (1..32)
NFUNC, 4, functions per pad (2..16)
SELW, derived = max(1, clog2(NFUNC)), localparam, select width per pad
GUARD, 2, park duration in clk cycles (1..15)
SYNC_STAGES, 2, input synchroniser depth (0 = bypass, else 2..3)
IDLE_VAL, {NFUNC{1'b1}}, NFUNC-bit vector; bit f = level seen by function f when not selected

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
io_in  in  COUNT  pad input
io_out  out  COUNT  pad output
io_oeb  out  COUNT  pad output-enable, active-low
p_in  out  COUNT*NFUNC  peripheral inputs; index i*NFUNC+f
p_out  in  COUNT*NFUNC  peripheral outputs
p_oeb  in  COUNT*NFUNC  peripheral output-enables, active-low
sel_we  in  1  write strobe, sampled on clk rising edge
sel_wmask  in  COUNT  per-pad write enable
sel_wdata  in  COUNT*SELW  new selections; field i at [i*SELW +: SELW]
cur_sel  out  COUNT*SELW  active selection per pad
sel_busy  out  1  OR of all pads in PARK
sel_err  out  1  one-cycle pulse: a write carried a value >= NFUNC

Behaviour:
- One clock domain. Reset is asynchronous, active-high.
- Per pad: registers cur_sel, pend_sel, cnt (4 bit), state {ACTIVE, PARK}, sync chain.
- Reset values: cur_sel=0, pend_sel=0, cnt=0, state=ACTIVE, sync flops=0, sel_err=0. After reset: io_out/io_oeb follow function 0 and sel_busy=0. Reset during PARK abandons the pending change; the pad returns to function 0.
- Accepted write to pad i: sel_we=1 and sel_wmask[i]=1 and field i < NFUNC.
- Field i >= NFUNC: the pad is unchanged, and sel_err=1 on the following cycle.
- ACTIVE, accepted write with value == cur_sel: no action.
- ACTIVE, accepted write with value != cur_sel: pend_sel<=value, cnt<=GUARD, state<=PARK.
- PARK: cnt decrements each cycle. When cnt==1: cur_sel<=pend_sel and state<=ACTIVE. PARK therefore lasts exactly GUARD cycles.
- PARK, accepted write (any value, including cur_sel): pend_sel<=value, cnt<=GUARD (restart).
- Timing: write sampled at edge T. Pad is parked from T through T+GUARD. The new function drives after edge T+GUARD.
- Output path, ACTIVE: io_out[i]=p_out[i*NFUNC+cur_sel], io_oeb[i]=p_oeb[i*NFUNC+cur_sel]. This path is combinational; latency 0 from p_out/p_oeb.
- Output path, PARK: io_out[i]=0, io_oeb[i]=1.
- Input path: s[i] = io_in[i] delayed by SYNC_STAGES flops (SYNC_STAGES=0: s[i]=io_in[i]).
- p_in[i*NFUNC+f] = s[i] when state==ACTIVE and cur_sel==f; otherwise IDLE_VAL[f]. During PARK, all functions on the pad see their idle level.
- cur_sel output mirrors the registers. It updates at the same edge the pad leaves PARK.
- Pads are independent. Simultaneous writes to several pads are each processed in the same cycle.

Decomposition:
- Package ef_pin_mux_pkg: state encoding (ACTIVE=0, PARK=1), clog2 function, GUARD counter width constant (4).
- Sub-module ef_pin_mux_slice: one pad (FSM, counter, synchroniser, output/input muxes), parameters NFUNC, SELW, GUARD, SYNC_STAGES, IDLE_VAL. The top instantiates it COUNT times in a generate loop, ORs busy, and ORs the registered per-pad error flags into sel_err.

Test Plan:
- Reset: assert rst mid-cycle with p_out[0]=1, p_oeb[0]=0 -> io_out[0]=1, io_oeb[0]=0 immediately; cur_sel=0; sel_busy=0.
- Switch: GUARD=2, write pad 3 sel=2 at edge T -> io_oeb[3]=1, io_out[3]=0, sel_busy=1 for 2 cycles; then pad 3 follows p_out[14]/p_oeb[14]; cur_sel field 3=2.
- Restart: write pad 1 sel=1, then sel=3 one cycle later -> park lasts 3 cycles total; final cur_sel=3; function 1 never drives the pad.
- Same value / mask: write pad 5 with its current sel -> no park; sel_wmask[5]=0 with a different value -> no change.
- Error: NFUNC=3, write value 3 -> sel_err pulses one cycle; pad unchanged; other masked pads in the same write still switch.
- Input gating: SYNC_STAGES=2, pad 0 on function 1, io_in[0] 0->1 -> p_in[1] rises after 2 edges; p_in[0], p_in[2], p_in[3] stay at IDLE_VAL (1); during PARK p_in[1]=1 (idle).
